// File: rtl/spi_slave_fifo.sv
// SPI slave with TX/RX FIFOs, fully PCLK-synchronous: the SPI pins are oversampled,
// so SCK edges are detected as PCLK-domain events rather than used as a clock.
module spi_slave_fifo #(
  parameter int DATA_W      = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              spi_en,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  input  logic              sck_i,
  input  logic              ss_n_i,
  input  logic              mosi_i,
  output logic              miso_o,
  output logic              miso_oe_o,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_wr,
  output logic              tx_full,
  output logic [DATA_W-1:0] rx_data,
  input  logic              rx_rd,
  output logic              rx_empty,
  input  logic [3:0]        irq_en,
  input  logic [3:0]        int_clr,
  output logic [3:0]        status,
  output logic              irq
);

  localparam int CW    = $clog2(DATA_W);
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PW + 1;
  localparam logic [CW-1:0]    LAST_BIT = CW'(DATA_W - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d, ss_sync_q, ss_sync_d, mosi_sync_q, mosi_sync_d;
  logic sck_dly_q, ss_dly_q;
  logic cpol_q, cpol_d, cpha_q, cpha_d, lsb_q, lsb_d, hold_q, hold_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
  logic miso_q, miso_d, oe_q, oe_d;
  logic udf_q, udf_d, ovf_q, ovf_d, irq_q, irq_d;

  logic sck_s, ss_s, mosi_s, sck_edge, lead, trail, sample, advance, ss_fall;
  logic load, tx_pop, rx_push, udf_set, ovf_set;

  logic [DATA_W-1:0] tx_mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] tx_mem_d [FIFO_DEPTH];
  logic [DATA_W-1:0] rx_mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] rx_mem_d [FIFO_DEPTH];
  logic [PW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d, rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic tx_empty, rx_full, tx_push_ok, tx_pop_ok, rx_push_ok, rx_pop_ok;
  logic [DATA_W-1:0] tx_head;

  assign sck_s  = sck_sync_q[SYNC_STAGES-1];
  assign ss_s   = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // Sync chains reset to 0 so a low ss_n at reset release never looks like a fall.
  assign sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], sck_i};
  assign ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], ss_n_i};
  assign mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};

  assign sck_edge = sck_s ^ sck_dly_q;
  assign lead     = sck_edge && (sck_s != cpol_q);
  assign trail    = sck_edge && (sck_s == cpol_q);
  assign sample   = cpha_q ? trail : lead;
  assign advance  = cpha_q ? lead : trail;
  assign ss_fall  = ss_dly_q && !ss_s;

  // FIFOs: a pop is ignored when empty; a push into a full FIFO only lands if a pop frees a slot.
  assign tx_empty = (tx_cnt_q == '0);
  assign tx_full  = (tx_cnt_q == FULL_CNT);
  assign rx_empty = (rx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == FULL_CNT);
  assign tx_head  = tx_mem_q[tx_rp_q];
  assign rx_data  = rx_empty ? '0 : rx_mem_q[rx_rp_q];

  always_comb begin
    tx_pop_ok  = tx_pop && !tx_empty;
    tx_push_ok = tx_wr && (!tx_full || tx_pop_ok);
    rx_pop_ok  = rx_rd && !rx_empty;
    rx_push_ok = rx_push && (!rx_full || rx_pop_ok);
    tx_mem_d = tx_mem_q;
    rx_mem_d = rx_mem_q;
    tx_wp_d  = tx_wp_q;
    tx_rp_d  = tx_rp_q;
    rx_wp_d  = rx_wp_q;
    rx_rp_d  = rx_rp_q;
    if (tx_push_ok) begin
      tx_mem_d[tx_wp_q] = tx_data;
      tx_wp_d = tx_wp_q + PW'(1);
    end
    if (tx_pop_ok) tx_rp_d = tx_rp_q + PW'(1);
    if (rx_push_ok) begin
      rx_mem_d[rx_wp_q] = rx_sh_d;
      rx_wp_d = rx_wp_q + PW'(1);
    end
    if (rx_pop_ok) rx_rp_d = rx_rp_q + PW'(1);
    tx_cnt_d = tx_cnt_q + CNT_W'(tx_push_ok) - CNT_W'(tx_pop_ok);
    rx_cnt_d = rx_cnt_q + CNT_W'(rx_push_ok) - CNT_W'(rx_pop_ok);
  end

  // hold_q suppresses the next advance edge so a freshly loaded first bit is not shifted away.
  always_comb begin
    state_d   = state_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    lsb_d     = lsb_q;
    hold_d    = hold_q;
    bit_cnt_d = bit_cnt_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    load      = 1'b0;
    tx_pop    = 1'b0;
    rx_push   = 1'b0;
    udf_set   = 1'b0;
    ovf_set   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        bit_cnt_d = '0;
        if (spi_en && ss_fall) begin
          state_d = ST_SHIFT;
          cpol_d  = cpol;
          cpha_d  = cpha;
          lsb_d   = lsb_first;
          hold_d  = cpha;
          rx_sh_d = '0;
          load    = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (!spi_en || ss_s) begin
          state_d   = ST_IDLE;
          bit_cnt_d = '0;
        end else begin
          if (advance) begin
            if (hold_q) hold_d = 1'b0;
            else if (lsb_q) tx_sh_d = {1'b0, tx_sh_q[DATA_W-1:1]};
            else tx_sh_d = {tx_sh_q[DATA_W-2:0], 1'b0};
          end
          if (sample) begin
            rx_sh_d = lsb_q ? {mosi_s, rx_sh_q[DATA_W-1:1]} : {rx_sh_q[DATA_W-2:0], mosi_s};
            if (bit_cnt_q == LAST_BIT) begin
              bit_cnt_d = '0;
              rx_push   = 1'b1;
              ovf_set   = rx_full && !rx_rd;
              load      = 1'b1;
              hold_d    = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + CW'(1);
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (load) begin
      if (tx_empty) begin
        tx_sh_d = '0;
        udf_set = 1'b1;
      end else begin
        tx_sh_d = tx_head;
        tx_pop  = 1'b1;
      end
    end
    oe_d   = (state_d == ST_SHIFT);
    miso_d = oe_d && (lsb_d ? tx_sh_d[0] : tx_sh_d[DATA_W-1]);
    udf_d  = udf_set || (udf_q && !int_clr[3]);
    ovf_d  = ovf_set || (ovf_q && !int_clr[2]);
    irq_d  = |(status & irq_en);
  end

  assign status    = {udf_q, ovf_q, tx_empty, !rx_empty};
  assign irq       = irq_q;
  assign miso_o    = miso_q;
  assign miso_oe_o = oe_q;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= ST_IDLE;
      sck_sync_q  <= '0;
      ss_sync_q   <= '0;
      mosi_sync_q <= '0;
      sck_dly_q   <= 1'b0;
      ss_dly_q    <= 1'b0;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      lsb_q       <= 1'b0;
      hold_q      <= 1'b0;
      bit_cnt_q   <= '0;
      tx_sh_q     <= '0;
      rx_sh_q     <= '0;
      miso_q      <= 1'b0;
      oe_q        <= 1'b0;
      udf_q       <= 1'b0;
      ovf_q       <= 1'b0;
      irq_q       <= 1'b0;
      tx_mem_q    <= '{default: '0};
      rx_mem_q    <= '{default: '0};
      tx_wp_q     <= '0;
      tx_rp_q     <= '0;
      rx_wp_q     <= '0;
      rx_rp_q     <= '0;
      tx_cnt_q    <= '0;
      rx_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      sck_sync_q  <= sck_sync_d;
      ss_sync_q   <= ss_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sck_dly_q   <= sck_s;
      ss_dly_q    <= ss_s;
      cpol_q      <= cpol_d;
      cpha_q      <= cpha_d;
      lsb_q       <= lsb_d;
      hold_q      <= hold_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_sh_q     <= tx_sh_d;
      rx_sh_q     <= rx_sh_d;
      miso_q      <= miso_d;
      oe_q        <= oe_d;
      udf_q       <= udf_d;
      ovf_q       <= ovf_d;
      irq_q       <= irq_d;
      tx_mem_q    <= tx_mem_d;
      rx_mem_q    <= rx_mem_d;
      tx_wp_q     <= tx_wp_d;
      tx_rp_q     <= tx_rp_d;
      rx_wp_q     <= rx_wp_d;
      rx_rp_q     <= rx_rp_d;
      tx_cnt_q    <= tx_cnt_d;
      rx_cnt_q    <= rx_cnt_d;
    end
  end

endmodule
